// File: rtl/seq_pkg.sv
// Shared definitions for the sequential library counters.
// Overflow modes and a width-agnostic clamp helper.
package seq_pkg;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    // Works on 33 bits so callers up to 32 bits wide can share it.
    function automatic logic [32:0] clamp_to_max(
        input logic [32:0] value,
        input logic [32:0] max_val
    );
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-count arithmetic for the up/down counter.
// Sums are one bit wider than the count so limit detection is exact.
module updown_next_calc
    import seq_pkg::*;
#(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] s,
    input  logic             up_down,
    output logic [WIDTH-1:0] next_count,
    output logic             limit_hit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] wrap_up;
    logic [WIDTH:0] wrap_down;
    logic           over;
    logic           under;

    assign sum   = {1'b0, count} + {1'b0, s};
    assign over  = sum > {1'b0, MAX_VAL};
    assign under = count < s;

    // Modulus is MAX_VAL+1; s never exceeds MAX_VAL so these stay in range.
    assign wrap_up   = sum - {1'b0, MAX_VAL} - 1'b1;
    assign wrap_down = {1'b0, count} + {1'b0, MAX_VAL} - {1'b0, s} + 1'b1;

    always_comb begin
        next_count = count;
        limit_hit  = 1'b0;
        if (up_down) begin
            if (over) begin
                limit_hit  = 1'b1;
                next_count = (SATURATE == MODE_SAT) ? MAX_VAL
                                                    : WIDTH'(wrap_up);
            end else begin
                next_count = WIDTH'(sum);
            end
        end else begin
            if (under) begin
                limit_hit  = 1'b1;
                next_count = (SATURATE == MODE_SAT) ? '0
                                                    : WIDTH'(wrap_down);
            end else begin
                next_count = count - s;
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with clear, load, step and wrap/saturate.
// Cascade by feeding tc of one stage into en of the next.
module updown_counter_param
    import seq_pkg::*;
#(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_down,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf_sticky,
    output logic             at_max,
    output logic             at_min
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter_param: WIDTH must be 2..32");
    end
    if (MAX_VAL == '0) begin : g_bad_max
        $error("updown_counter_param: MAX_VAL must be >= 1");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_reset
        $error("updown_counter_param: RESET_VAL exceeds MAX_VAL");
    end

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             ovf_q;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_count;
    logic             limit_hit;

    assign s            = WIDTH'(clamp_to_max(33'(step), 33'(MAX_VAL)));
    assign load_clamped = WIDTH'(clamp_to_max(33'(load_val), 33'(MAX_VAL)));

    updown_next_calc #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count_q),
        .s          (s),
        .up_down    (up_down),
        .next_count (next_count),
        .limit_hit  (limit_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clr) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            count_q <= load_clamped;
            tc_q    <= 1'b0;
        end else if (en) begin
            count_q <= next_count;
            tc_q    <= limit_hit;
            ovf_q   <= ovf_q | limit_hit;
        end else begin
            tc_q    <= 1'b0;
        end
    end

    assign count      = count_q;
    assign tc         = tc_q;
    assign ovf_sticky = ovf_q;
    assign at_max     = (count_q == MAX_VAL);
    assign at_min     = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: directed scenarios on 4-bit instances
// and a randomized run of two 8-bit instances against an arithmetic model.
module tb_updown_counter_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-bit group: dut_a (MAX 9, wrap) and dut_b (MAX 15, saturate)
    logic       a_clr, a_load, a_en, a_ud;
    logic [3:0] a_lv, a_step;
    logic [3:0] a_cnt, b_cnt;
    logic       a_tc, a_ovf, a_max, a_min;
    logic       b_tc, b_ovf, b_max, b_min;

    // 8-bit group: dut_w (MAX 200, wrap) and dut_s (MAX 200, saturate)
    logic       w_clr, w_load, w_en, w_ud;
    logic [7:0] w_lv, w_step;
    logic [7:0] w_cnt, s_cnt;
    logic       w_tc, w_ovf, w_max, w_min;
    logic       s_tc, s_ovf, s_max, s_min;

    updown_counter_param #(
        .WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'd0), .SATURATE(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load),
        .load_val(a_lv), .en(a_en), .up_down(a_ud), .step(a_step),
        .count(a_cnt), .tc(a_tc), .ovf_sticky(a_ovf),
        .at_max(a_max), .at_min(a_min)
    );

    updown_counter_param #(
        .WIDTH(4), .MAX_VAL(4'd15), .RESET_VAL(4'd0), .SATURATE(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load),
        .load_val(a_lv), .en(a_en), .up_down(a_ud), .step(a_step),
        .count(b_cnt), .tc(b_tc), .ovf_sticky(b_ovf),
        .at_max(b_max), .at_min(b_min)
    );

    updown_counter_param #(
        .WIDTH(8), .MAX_VAL(8'd200), .RESET_VAL(8'd17), .SATURATE(1'b0)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .clr(w_clr), .load(w_load),
        .load_val(w_lv), .en(w_en), .up_down(w_ud), .step(w_step),
        .count(w_cnt), .tc(w_tc), .ovf_sticky(w_ovf),
        .at_max(w_max), .at_min(w_min)
    );

    updown_counter_param #(
        .WIDTH(8), .MAX_VAL(8'd200), .RESET_VAL(8'd17), .SATURATE(1'b1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(w_clr), .load(w_load),
        .load_val(w_lv), .en(w_en), .up_down(w_ud), .step(w_step),
        .count(s_cnt), .tc(s_tc), .ovf_sticky(s_ovf),
        .at_max(s_max), .at_min(s_min)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one clock edge of the counter in plain arithmetic.
    function automatic void model_step(
        input int max, input bit sat, input int rv,
        inout int c, inout bit t, inout bit o,
        input bit clr, input bit load, input int lv,
        input bit en, input bit ud, input int st
    );
        int sv;
        t = 1'b0;
        if (clr) begin
            c = rv;
            o = 1'b0;
        end else if (load) begin
            c = (lv > max) ? max : lv;
        end else if (en) begin
            sv = (st > max) ? max : st;
            if (ud) begin
                if (c + sv > max) begin
                    c = sat ? max : c + sv - (max + 1);
                    t = 1'b1;
                end else begin
                    c = c + sv;
                end
            end else begin
                if (c < sv) begin
                    c = sat ? 0 : c + (max + 1) - sv;
                    t = 1'b1;
                end else begin
                    c = c - sv;
                end
            end
            if (t) o = 1'b1;
        end
    endfunction

    task automatic test_reset();
        checks++;
        if (a_cnt !== 4'd0 || a_tc !== 1'b0 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: cnt=%0d tc=%b ovf=%b, want 0 0 0",
                     a_cnt, a_tc, a_ovf);
        end
        checks++;
        if (a_min !== 1'b1 || a_max !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: min=%b max=%b, want 1 0",
                     a_min, a_max);
        end
        checks++;
        if (w_cnt !== 8'd17 || s_cnt !== 8'd17 || w_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_w: w=%0d s=%0d ovf=%b, want 17 17 0",
                     w_cnt, s_cnt, w_ovf);
        end
    endtask

    task automatic test_async_reset();
        a_load = 1; a_lv = 4'd9;
        tick();
        a_load = 0; a_en = 1; a_ud = 1; a_step = 4'd1;
        tick();
        a_en = 0; a_load = 1; a_lv = 4'd6;
        tick();
        a_load = 0;
        checks++;
        if (a_cnt !== 4'd6 || a_ovf !== 1'b1 || a_tc !== 1'b0) begin
            errors++;
            $display("FAIL pre_async: cnt=%0d ovf=%b tc=%b, want 6 1 0",
                     a_cnt, a_ovf, a_tc);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (a_cnt !== 4'd0 || a_tc !== 1'b0 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d tc=%b ovf=%b, want 0 0 0",
                     a_cnt, a_tc, a_ovf);
        end
        rst_n = 1;
    endtask

    task automatic test_count_up();
        int e;
        a_en = 1; a_ud = 1; a_step = 4'd1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            e = i % 10;
            checks++;
            if (a_cnt !== 4'(e) || a_tc !== (e == 0)
                || a_max !== (e == 9)) begin
                errors++;
                $display("FAIL count_up[%0d]: cnt=%0d tc=%b max=%b, want %0d %b %b",
                         i, a_cnt, a_tc, a_max, e, (e == 0), (e == 9));
            end
        end
        a_en = 0;
    endtask

    task automatic test_down_wrap();
        a_clr = 1;
        tick();
        a_clr = 0;
        checks++;
        if (a_cnt !== 4'd0 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr: cnt=%0d ovf=%b, want 0 0", a_cnt, a_ovf);
        end
        a_load = 1; a_lv = 4'd2;
        tick();
        a_load = 0; a_en = 1; a_ud = 0; a_step = 4'd3;
        tick();
        checks++;
        if (a_cnt !== 4'd9 || a_tc !== 1'b1 || a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap: cnt=%0d tc=%b ovf=%b, want 9 1 1",
                     a_cnt, a_tc, a_ovf);
        end
        a_en = 0;
        tick();
        checks++;
        if (a_cnt !== 4'd9 || a_tc !== 1'b0 || a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL tc_pulse: cnt=%0d tc=%b ovf=%b, want 9 0 1",
                     a_cnt, a_tc, a_ovf);
        end
        // step 12 clamps to 9: 5 + 10 - 9 = 6
        a_load = 1; a_lv = 4'd5;
        tick();
        a_load = 0; a_en = 1; a_ud = 0; a_step = 4'd12;
        tick();
        checks++;
        if (a_cnt !== 4'd6 || a_tc !== 1'b1) begin
            errors++;
            $display("FAIL step_clamp: cnt=%0d tc=%b, want 6 1", a_cnt, a_tc);
        end
        a_en = 0;
    endtask

    task automatic test_saturate();
        a_load = 1; a_lv = 4'd14;
        tick();
        a_load = 0; a_en = 1; a_ud = 1; a_step = 4'd5;
        tick();
        checks++;
        if (b_cnt !== 4'd15 || b_tc !== 1'b1 || b_ovf !== 1'b1
            || b_max !== 1'b1) begin
            errors++;
            $display("FAIL sat_up: cnt=%0d tc=%b ovf=%b max=%b, want 15 1 1 1",
                     b_cnt, b_tc, b_ovf, b_max);
        end
        tick();
        checks++;
        if (b_cnt !== 4'd15 || b_tc !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: cnt=%0d tc=%b, want 15 1", b_cnt, b_tc);
        end
        a_ud = 0; a_step = 4'd15;
        tick();
        checks++;
        if (b_cnt !== 4'd0 || b_tc !== 1'b0) begin
            errors++;
            $display("FAIL sat_down_exact: cnt=%0d tc=%b, want 0 0",
                     b_cnt, b_tc);
        end
        tick();
        checks++;
        if (b_cnt !== 4'd0 || b_tc !== 1'b1 || b_min !== 1'b1) begin
            errors++;
            $display("FAIL sat_down: cnt=%0d tc=%b min=%b, want 0 1 1",
                     b_cnt, b_tc, b_min);
        end
        a_en = 0;
        tick();
        checks++;
        if (b_tc !== 1'b0 || b_ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_idle: tc=%b ovf=%b, want 0 1", b_tc, b_ovf);
        end
    endtask

    task automatic test_priority();
        checks++;
        if (a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL prio_pre: ovf=%b, want 1", a_ovf);
        end
        a_clr = 1; a_load = 1; a_lv = 4'd7;
        a_en = 1; a_ud = 1; a_step = 4'd1;
        tick();
        checks++;
        if (a_cnt !== 4'd0 || a_ovf !== 1'b0 || a_tc !== 1'b0) begin
            errors++;
            $display("FAIL prio_clr: cnt=%0d ovf=%b tc=%b, want 0 0 0",
                     a_cnt, a_ovf, a_tc);
        end
        a_clr = 0; a_lv = 4'd12;
        tick();
        checks++;
        if (a_cnt !== 4'd9 || a_tc !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp: cnt=%0d tc=%b, want 9 0", a_cnt, a_tc);
        end
        a_load = 0;
        tick();
        a_load = 1; a_lv = 4'd3;
        tick();
        checks++;
        if (a_cnt !== 4'd3 || a_tc !== 1'b0 || a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL load_keeps_ovf: cnt=%0d tc=%b ovf=%b, want 3 0 1",
                     a_cnt, a_tc, a_ovf);
        end
        a_load = 0; a_en = 0;
    endtask

    task automatic test_hold();
        a_load = 1; a_lv = 4'd4;
        tick();
        a_load = 0; a_en = 0; a_step = 4'd1;
        for (int i = 0; i < 5; i++) begin
            a_ud = 1'(i);
            tick();
            checks++;
            if (a_cnt !== 4'd4 || a_tc !== 1'b0) begin
                errors++;
                $display("FAIL hold_en0[%0d]: cnt=%0d tc=%b, want 4 0",
                         i, a_cnt, a_tc);
            end
        end
        a_en = 1; a_step = 4'd0;
        for (int i = 0; i < 3; i++) begin
            a_ud = 1'(i);
            tick();
            checks++;
            if (a_cnt !== 4'd4 || a_tc !== 1'b0) begin
                errors++;
                $display("FAIL hold_step0[%0d]: cnt=%0d tc=%b, want 4 0",
                         i, a_cnt, a_tc);
            end
        end
        a_en = 0;
    endtask

    task automatic test_random();
        int wc = 17, sc = 17;
        bit wt = 0, wo = 0, st = 0, so = 0;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                #2 rst_n = 0;
                #1;
                wc = 17; sc = 17; wt = 0; wo = 0; st = 0; so = 0;
                checks++;
                if (w_cnt !== 8'd17 || s_cnt !== 8'd17
                    || w_ovf !== 1'b0 || s_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_async: w=%0d s=%0d, want 17 17",
                             w_cnt, s_cnt);
                end
                rst_n = 1;
            end
            w_clr  = ($urandom_range(0, 31) == 0);
            w_load = ($urandom_range(0, 15) == 0);
            w_en   = ($urandom_range(0, 3) != 0);
            w_ud   = 1'($urandom_range(0, 1));
            w_lv   = 8'($urandom_range(0, 255));
            w_step = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 6));
            tick();
            model_step(200, 1'b0, 17, wc, wt, wo, w_clr, w_load,
                       int'(w_lv), w_en, w_ud, int'(w_step));
            model_step(200, 1'b1, 17, sc, st, so, w_clr, w_load,
                       int'(w_lv), w_en, w_ud, int'(w_step));
            checks++;
            if (w_cnt !== 8'(wc) || w_tc !== wt || w_ovf !== wo
                || w_max !== (wc == 200) || w_min !== (wc == 0)) begin
                errors++;
                $display("FAIL rand_wrap[%0d]: cnt=%0d tc=%b ovf=%b, want %0d %b %b",
                         i, w_cnt, w_tc, w_ovf, wc, wt, wo);
            end
            checks++;
            if (s_cnt !== 8'(sc) || s_tc !== st || s_ovf !== so
                || s_max !== (sc == 200) || s_min !== (sc == 0)) begin
                errors++;
                $display("FAIL rand_sat[%0d]: cnt=%0d tc=%b ovf=%b, want %0d %b %b",
                         i, s_cnt, s_tc, s_ovf, sc, st, so);
            end
        end
        w_en = 0; w_clr = 0; w_load = 0;
    endtask

    initial begin
        rst_n = 0;
        a_clr = 0; a_load = 0; a_en = 0; a_ud = 0; a_lv = '0; a_step = '0;
        w_clr = 0; w_load = 0; w_en = 0; w_ud = 0; w_lv = '0; w_step = '0;
        #12;
        test_reset();
        rst_n = 1;
        tick();
        test_async_reset();
        test_count_up();
        test_down_wrap();
        test_saturate();
        test_priority();
        test_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
